// File: rtl/simple_pkg.sv
// simple_pkg -- constants shared by the EX/MEM pipeline slice.
//   FLAG_*     : bit positions inside the {S,Z,C,V} flag vector
//   br_cond_e  : branch condition encodings carried on br_cond
//   mem_ctrl_t : MEM-stage side-effect controls that must drop with m_valid
package simple_pkg;

  localparam int FLAG_W    = 4;
  localparam int FLAG_S    = 3;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_C    = 1;
  localparam int FLAG_V    = 0;

  localparam int RD_ADDR_W = 3;
  localparam int BR_COND_W = 3;

  // Encodings 100, 101 and 110 are reserved and never taken.
  typedef enum logic [BR_COND_W-1:0] {
    BR_BE     = 3'b000,
    BR_BLT    = 3'b001,
    BR_BLE    = 3'b010,
    BR_BNE    = 3'b011,
    BR_ALWAYS = 3'b111
  } br_cond_e;

  typedef struct packed {
    logic rd_we;
    logic mem_rd;
    logic mem_wr;
  } mem_ctrl_t;

endpackage

// File: rtl/br_cond_eval.sv
// br_cond_eval -- combinational branch condition decode.
//   flags   in  [3:0] architectural flags {S,Z,C,V}
//   br_cond in  [2:0] condition code (see simple_pkg::br_cond_e)
//   taken   out       condition holds for the given flags
module br_cond_eval
  import simple_pkg::*;
(
  input  logic [FLAG_W-1:0]    flags,
  input  logic [BR_COND_W-1:0] br_cond,
  output logic                 taken
);

  logic s_xor_v;
  logic unused_carry;

  assign s_xor_v      = flags[FLAG_S] ^ flags[FLAG_V];
  // No condition in this ISA consumes the carry flag.
  assign unused_carry = flags[FLAG_C];

  always_comb begin
    // NOTE: assigning a default before the case keeps this purely
    // combinational; a path that leaves 'taken' unassigned infers a latch.
    taken = 1'b0;
    case (br_cond)
      BR_BE:     taken = flags[FLAG_Z];
      BR_BLT:    taken = s_xor_v;
      BR_BLE:    taken = flags[FLAG_Z] | s_xor_v;
      BR_BNE:    taken = ~flags[FLAG_Z];
      BR_ALWAYS: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage -- EX->MEM pipeline register with flag register and
// branch resolution.
//   clk, rst (async, active-high)
//   stall, flush                     : pipeline control (flush wins)
//   ex_valid, alu_out, alu_cond,
//   cond_we, br_en, br_cond,
//   br_target, rd_addr, rd_we,
//   mem_rd, mem_wr, st_data          : EX-stage instruction
//   m_*                              : registered copies for MEM
//   flags                            : architectural {S,Z,C,V}
//   br_taken, br_pc                  : one-cycle redirect pulse and target
module ex_mem_stage
  import simple_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [FLAG_W-1:0] FLAG_RST = 4'b0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 ex_valid,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic [FLAG_W-1:0]    alu_cond,
  input  logic                 cond_we,
  input  logic                 br_en,
  input  logic [BR_COND_W-1:0] br_cond,
  input  logic [WIDTH-1:0]     br_target,
  input  logic [RD_ADDR_W-1:0] rd_addr,
  input  logic                 rd_we,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  input  logic [WIDTH-1:0]     st_data,
  output logic                 m_valid,
  output logic [WIDTH-1:0]     m_alu_out,
  output logic [RD_ADDR_W-1:0] m_rd_addr,
  output logic                 m_rd_we,
  output logic                 m_mem_rd,
  output logic                 m_mem_wr,
  output logic [WIDTH-1:0]     m_st_data,
  output logic [FLAG_W-1:0]    flags,
  output logic                 br_taken,
  output logic [WIDTH-1:0]     br_pc
);

  logic                 m_valid_q,   m_valid_d;
  logic [WIDTH-1:0]     m_alu_out_q, m_alu_out_d;
  logic [RD_ADDR_W-1:0] m_rd_addr_q, m_rd_addr_d;
  mem_ctrl_t            m_ctrl_q,    m_ctrl_d;
  logic [WIDTH-1:0]     m_st_data_q, m_st_data_d;
  logic [FLAG_W-1:0]    flags_q,     flags_d;
  logic                 br_taken_q,  br_taken_d;
  logic [WIDTH-1:0]     br_pc_q,     br_pc_d;

  logic cond_true;

  // Evaluated against the registered flags so a flag-setter one slot ahead
  // is visible, and a branch that also sets flags sees the old value.
  br_cond_eval u_br_cond_eval (
    .flags   (flags_q),
    .br_cond (br_cond),
    .taken   (cond_true)
  );

  always_comb begin
    m_valid_d   = m_valid_q;
    m_alu_out_d = m_alu_out_q;
    m_rd_addr_d = m_rd_addr_q;
    m_ctrl_d    = m_ctrl_q;
    m_st_data_d = m_st_data_q;
    flags_d     = flags_q;
    br_taken_d  = 1'b0;        // redirect is a pulse, never held
    br_pc_d     = br_pc_q;

    if (flush) begin
      // Killed slot: payload data may go stale, side effects may not.
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
    end else if (stall) begin
      // Everything holds; only the redirect pulse drops.
    end else if (ex_valid) begin
      m_valid_d   = 1'b1;
      m_alu_out_d = alu_out;
      m_rd_addr_d = rd_addr;
      m_ctrl_d    = '{rd_we: rd_we, mem_rd: mem_rd, mem_wr: mem_wr};
      m_st_data_d = st_data;
      if (cond_we) flags_d = alu_cond;
      if (br_en && cond_true) begin
        br_taken_d = 1'b1;
        br_pc_d    = br_target;
      end
    end else begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every register
    // samples the pre-edge value of every other; blocking here would make
    // the result depend on statement order.
    if (rst) begin
      m_valid_q   <= 1'b0;
      m_alu_out_q <= '0;
      m_rd_addr_q <= '0;
      m_ctrl_q    <= '0;
      m_st_data_q <= '0;
      flags_q     <= FLAG_RST;
      br_taken_q  <= 1'b0;
      br_pc_q     <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_alu_out_q <= m_alu_out_d;
      m_rd_addr_q <= m_rd_addr_d;
      m_ctrl_q    <= m_ctrl_d;
      m_st_data_q <= m_st_data_d;
      flags_q     <= flags_d;
      br_taken_q  <= br_taken_d;
      br_pc_q     <= br_pc_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_alu_out = m_alu_out_q;
  assign m_rd_addr = m_rd_addr_q;
  assign m_rd_we   = m_ctrl_q.rd_we;
  assign m_mem_rd  = m_ctrl_q.mem_rd;
  assign m_mem_wr  = m_ctrl_q.mem_wr;
  assign m_st_data = m_st_data_q;
  assign flags     = flags_q;
  assign br_taken  = br_taken_q;
  assign br_pc     = br_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage -- directed vectors for ex_mem_stage (WIDTH=16,
// FLAG_RST=0000). Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point, well away from the active edge.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, ex_valid;
  logic [15:0] alu_out;
  logic [3:0]  alu_cond;
  logic        cond_we, br_en;
  logic [2:0]  br_cond;
  logic [15:0] br_target;
  logic [2:0]  rd_addr;
  logic        rd_we, mem_rd, mem_wr;
  logic [15:0] st_data;
  logic        m_valid;
  logic [15:0] m_alu_out;
  logic [2:0]  m_rd_addr;
  logic        m_rd_we, m_mem_rd, m_mem_wr;
  logic [15:0] m_st_data;
  logic [3:0]  flags;
  logic        br_taken;
  logic [15:0] br_pc;

  int checks = 0;
  int errors = 0;

  ex_mem_stage #(.WIDTH(16), .FLAG_RST(4'b0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .ex_valid  (ex_valid),
    .alu_out   (alu_out),
    .alu_cond  (alu_cond),
    .cond_we   (cond_we),
    .br_en     (br_en),
    .br_cond   (br_cond),
    .br_target (br_target),
    .rd_addr   (rd_addr),
    .rd_we     (rd_we),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .st_data   (st_data),
    .m_valid   (m_valid),
    .m_alu_out (m_alu_out),
    .m_rd_addr (m_rd_addr),
    .m_rd_we   (m_rd_we),
    .m_mem_rd  (m_mem_rd),
    .m_mem_wr  (m_mem_wr),
    .m_st_data (m_st_data),
    .flags     (flags),
    .br_taken  (br_taken),
    .br_pc     (br_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; ex_valid = 0;
    alu_out = '0; alu_cond = '0; cond_we = 0;
    br_en = 0; br_cond = '0; br_target = '0;
    rd_addr = '0; rd_we = 0; mem_rd = 0; mem_wr = 0; st_data = '0;
  endtask

  // Accepted instruction that only writes flags.
  task automatic set_flags(input logic [3:0] f);
    idle_inputs();
    ex_valid = 1; cond_we = 1; alu_cond = f;
    tick();
    check("set_flags", flags, f);
  endtask

  // Accepted branch; checks the redirect outputs one cycle later.
  task automatic branch(input string tag, input logic [2:0] cc, input logic [15:0] tgt,
                        input logic exp_taken, input logic [15:0] exp_pc);
    idle_inputs();
    ex_valid = 1; br_en = 1; br_cond = cc; br_target = tgt;
    tick();
    check({tag, "_taken"}, br_taken, exp_taken);
    check({tag, "_pc"}, br_pc, exp_pc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_alu_out"}, m_alu_out, 0);
    check({tag, "_m_rd_addr"}, m_rd_addr, 0);
    check({tag, "_m_rd_we"}, m_rd_we, 0);
    check({tag, "_m_mem_rd"}, m_mem_rd, 0);
    check({tag, "_m_mem_wr"}, m_mem_wr, 0);
    check({tag, "_m_st_data"}, m_st_data, 0);
    check({tag, "_flags"}, flags, 4'b0000);
    check({tag, "_br_taken"}, br_taken, 0);
    check({tag, "_br_pc"}, br_pc, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1;
    tick();
    tick();
    check_all_zero("reset");

    // Release; the very next edge is a normal cycle.
    rst = 0;

    // Pass-through ADD.
    ex_valid = 1; alu_out = 16'h1234; rd_addr = 3'd5; rd_we = 1;
    tick();
    check("add_alu_out", m_alu_out, 16'h1234);
    check("add_rd_addr", m_rd_addr, 5);
    check("add_rd_we", m_rd_we, 1);
    check("add_valid", m_valid, 1);
    check("add_br_taken", br_taken, 0);

    // Bubble: valid and side effects drop, payload holds.
    idle_inputs();
    alu_out = 16'hFFFF; rd_we = 1; mem_rd = 1; mem_wr = 1;
    tick();
    check("bubble_valid", m_valid, 0);
    check("bubble_rd_we", m_rd_we, 0);
    check("bubble_mem_rd", m_mem_rd, 0);
    check("bubble_mem_wr", m_mem_wr, 0);
    check("bubble_alu_hold", m_alu_out, 16'h1234);
    check("bubble_rd_addr_hold", m_rd_addr, 5);

    // CMP sets Z, then BE taken, pulse lasts one cycle, then BNE not taken.
    set_flags(4'b0100);
    branch("be", 3'b000, 16'h0040, 1, 16'h0040);
    idle_inputs();
    tick();
    check("be_pulse_end", br_taken, 0);
    check("be_pc_hold", br_pc, 16'h0040);
    branch("bne", 3'b011, 16'h0080, 0, 16'h0040);

    // Signed compares.
    set_flags(4'b1000);
    branch("blt_sv10", 3'b001, 16'h0100, 1, 16'h0100);
    branch("ble_sv10", 3'b010, 16'h0104, 1, 16'h0104);
    set_flags(4'b1001);
    branch("blt_sv11", 3'b001, 16'h0108, 0, 16'h0104);
    branch("ble_sv11", 3'b010, 16'h010C, 0, 16'h0104);

    // Branch that also sets flags: judged on the old flags (Z=0).
    idle_inputs();
    ex_valid = 1; br_en = 1; br_cond = 3'b000; br_target = 16'h0110;
    cond_we = 1; alu_cond = 4'b0100;
    tick();
    check("be_setflag_taken", br_taken, 0);
    check("be_setflag_flags", flags, 4'b0100);
    branch("be_after", 3'b000, 16'h0114, 1, 16'h0114);

    // Reserved code never taken, unconditional always taken.
    branch("rsv100", 3'b100, 16'h0118, 0, 16'h0114);
    branch("rsv110", 3'b110, 16'h011C, 0, 16'h0114);
    branch("always", 3'b111, 16'h0200, 1, 16'h0200);

    // Plain ALU op, then stall three cycles with a taken BE in EX.
    idle_inputs();
    ex_valid = 1; alu_out = 16'h5555; rd_addr = 3'd2; rd_we = 1;
    tick();
    check("pre_stall_alu", m_alu_out, 16'h5555);
    idle_inputs();
    ex_valid = 1; stall = 1; br_en = 1; br_cond = 3'b000; br_target = 16'h0300;
    alu_out = 16'hAAAA; rd_addr = 3'd3; mem_wr = 1; st_data = 16'h1357;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_alu", m_alu_out, 16'h5555);
      check("stall_rd_addr", m_rd_addr, 2);
      check("stall_rd_we", m_rd_we, 1);
      check("stall_mem_wr", m_mem_wr, 0);
      check("stall_valid", m_valid, 1);
      check("stall_flags", flags, 4'b0100);
      check("stall_br_taken", br_taken, 0);
      check("stall_br_pc", br_pc, 16'h0200);
    end
    stall = 0;
    tick();
    check("release_taken", br_taken, 1);
    check("release_pc", br_pc, 16'h0300);
    check("release_alu", m_alu_out, 16'hAAAA);
    check("release_mem_wr", m_mem_wr, 1);
    check("release_st_data", m_st_data, 16'h1357);
    idle_inputs();
    tick();
    check("release_pulse_end", br_taken, 0);

    // Flush overrides stall on a flag-setting store with a branch.
    idle_inputs();
    ex_valid = 1; stall = 1; flush = 1; mem_wr = 1; st_data = 16'hBEEF;
    cond_we = 1; alu_cond = 4'b1111; br_en = 1; br_cond = 3'b111; br_target = 16'h0500;
    tick();
    check("flush_valid", m_valid, 0);
    check("flush_mem_wr", m_mem_wr, 0);
    check("flush_flags", flags, 4'b0100);
    check("flush_br_taken", br_taken, 0);
    check("flush_st_hold", m_st_data, 16'h1357);
    check("flush_pc_hold", br_pc, 16'h0300);

    // Asynchronous reset while a redirect pulse is live.
    branch("pre_rst", 3'b111, 16'h0400, 1, 16'h0400);
    stall = 1;
    rst = 1;
    #1;
    check_all_zero("async_rst");
    tick();
    rst = 0;
    idle_inputs();
    tick();
    check("post_rst_taken", br_taken, 0);
    check("post_rst_valid", m_valid, 0);
    check("post_rst_pc", br_pc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
